// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types and constants for the forwarding/hazard unit.
package forwarding_hazard_unit_pkg;

  localparam int unsigned REG_W = 5;

  // Operand mux select encoding {Ctrl1, Ctrl2}
  localparam logic [1:0] SEL_RF     = 2'b00;
  localparam logic [1:0] SEL_EXMEM  = 2'b01;
  localparam logic [1:0] SEL_MEMWB  = 2'b10;
  localparam logic [1:0] SEL_POSTWB = 2'b11;

  // One in-flight instruction as seen by the unit
  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             mem_read;
  } slot_t;

  // True when the slot will write back the given register
  function automatic logic slot_hits(slot_t s, logic [REG_W-1:0] r);
    return s.reg_write && (s.dest == r);
  endfunction

endpackage

// File: rtl/forwarding_hazard_unit_fwd_select_logic.sv
// Priority comparator choosing the forwarding source for one ALU operand.
module fwd_select_logic
  import forwarding_hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  slot_t            ex_slot,
  input  slot_t            mem_slot,
  input  slot_t            wb_slot,
  output logic [1:0]       sel
);

  // Nearest producer wins; $0 and unused operands always read the register file
  always_comb begin
    sel = SEL_RF;
    if (used && (src != '0)) begin
      if (slot_hits(ex_slot, src)) begin
        sel = SEL_EXMEM;
      end else if (slot_hits(mem_slot, src)) begin
        sel = SEL_MEMWB;
      end else if (slot_hits(wb_slot, src)) begin
        sel = SEL_POSTWB;
      end
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Tracks the three instructions ahead of ID, registers operand-mux selects for
// EX and raises a one-cycle stall on load-use hazards.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned NUM_FWD  = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [REG_BITS-1:0] ID_Rs,
  input  logic [REG_BITS-1:0] ID_Rt,
  input  logic                ID_UsesRs,
  input  logic                ID_UsesRt,
  input  logic [REG_BITS-1:0] ID_Dest,
  input  logic                ID_RegWrite,
  input  logic                ID_MemRead,
  input  logic                Flush,
  output logic                FwdA_Ctrl1,
  output logic                FwdA_Ctrl2,
  output logic                FwdB_Ctrl1,
  output logic                FwdB_Ctrl2,
  output logic                Stall,
  output logic                PCWrite,
  output logic                IFIDWrite,
  output logic                BubbleEX
);

  slot_t ex_q, mem_q, wb_q;
  slot_t id_slot;

  logic [NUM_FWD-1:0][REG_BITS-1:0] src_vec;
  logic [NUM_FWD-1:0]               used_vec;
  logic [NUM_FWD-1:0][1:0]          sel_d;
  logic [NUM_FWD-1:0][1:0]          sel_q;

  logic load_in_ex;

  // Operand 0 is Rs (ALU A), operand 1 is Rt (ALU B)
  always_comb begin
    src_vec     = '0;
    used_vec    = '0;
    src_vec[0]  = ID_Rs;
    src_vec[1]  = ID_Rt;
    used_vec[0] = ID_UsesRs;
    used_vec[1] = ID_UsesRt;
    id_slot     = '{dest: ID_Dest, reg_write: ID_RegWrite, mem_read: ID_MemRead};
  end

  // Load-use detection and bubble control; a flush suppresses the stall
  always_comb begin
    load_in_ex = ex_q.mem_read && ex_q.reg_write && (ex_q.dest != '0);
    Stall      = load_in_ex && !Flush &&
                 ((ID_UsesRs && (ex_q.dest == ID_Rs)) ||
                  (ID_UsesRt && (ex_q.dest == ID_Rt)));
    BubbleEX   = Stall || Flush;
    PCWrite    = !Stall;
    IFIDWrite  = !Stall;
  end

  for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
    fwd_select_logic u_sel (
      .src      (src_vec[i]),
      .used     (used_vec[i]),
      .ex_slot  (ex_q),
      .mem_slot (mem_q),
      .wb_slot  (wb_q),
      .sel      (sel_d[i])
    );
  end

  // Advance the slot pipeline; a bubble enters EX instead of the ID instruction
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= BubbleEX ? '0 : id_slot;
    end
  end

  // Selects land with the instruction entering EX; bubbles read the register file
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sel_q <= '0;
    end else if (BubbleEX) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign FwdA_Ctrl1 = sel_q[0][1];
  assign FwdA_Ctrl2 = sel_q[0][0];
  assign FwdB_Ctrl1 = sel_q[1][1];
  assign FwdB_Ctrl2 = sel_q[1][0];

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed self-checking bench for forwarding_hazard_unit.
module tb_forwarding_hazard_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] ID_Rs, ID_Rt, ID_Dest;
  logic       ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead, Flush;
  logic       FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2;
  logic       Stall, PCWrite, IFIDWrite, BubbleEX;

  int checks = 0;
  int errors = 0;

  forwarding_hazard_unit #(
    .REG_BITS (5),
    .NUM_FWD  (2)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .ID_Rs       (ID_Rs),
    .ID_Rt       (ID_Rt),
    .ID_UsesRs   (ID_UsesRs),
    .ID_UsesRt   (ID_UsesRt),
    .ID_Dest     (ID_Dest),
    .ID_RegWrite (ID_RegWrite),
    .ID_MemRead  (ID_MemRead),
    .Flush       (Flush),
    .FwdA_Ctrl1  (FwdA_Ctrl1),
    .FwdA_Ctrl2  (FwdA_Ctrl2),
    .FwdB_Ctrl1  (FwdB_Ctrl1),
    .FwdB_Ctrl2  (FwdB_Ctrl2),
    .Stall       (Stall),
    .PCWrite     (PCWrite),
    .IFIDWrite   (IFIDWrite),
    .BubbleEX    (BubbleEX)
  );

  always #5 Clk = ~Clk;

  task automatic set_id(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] dest, input logic rw,
                        input logic mr, input logic fl);
    ID_Rs = rs; ID_UsesRs = urs; ID_Rt = rt; ID_UsesRt = urt;
    ID_Dest = dest; ID_RegWrite = rw; ID_MemRead = mr; Flush = fl;
  endtask

  task automatic nop();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    nop();
    #2;
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2});
    end
    checks++;
    if ({Stall, PCWrite, IFIDWrite, BubbleEX} !== 4'b0110) begin
      errors++;
      $display("FAIL reset_status: got %b expected 0110",
               {Stall, PCWrite, IFIDWrite, BubbleEX});
    end
    Flush = 1'b1;
    #1;
    checks++;
    if (BubbleEX !== 1'b1) begin
      errors++;
      $display("FAIL reset_bubble_flush: got %b expected 1", BubbleEX);
    end
    Flush = 1'b0;
    step();
    Reset = 1'b0;
    step();
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2, Stall, PCWrite} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_release: got %b expected 000001",
               {FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2, Stall, PCWrite});
    end
  endtask

  // add $3 then sub reading Rs=3 in the very next slot
  task automatic test_fwd_a_exmem();
    drain();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    set_id(5'd3, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++;
      $display("FAIL fwd_a_no_stall: got %b expected 0", Stall);
    end
    step();
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2} !== 4'b0100) begin
      errors++;
      $display("FAIL fwd_a_exmem: got %b expected 0100",
               {FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2});
    end
  endtask

  // add $3, n nops, then an instruction reading Rt=3
  task automatic test_fwd_b_distance(input int n, input logic [1:0] exp);
    drain();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < n; i++) begin
      nop();
      step();
    end
    set_id(5'd9, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2} !== {2'b00, exp}) begin
      errors++;
      $display("FAIL fwd_b_dist%0d: got %b expected %b", n,
               {FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2}, {2'b00, exp});
    end
  endtask

  task automatic test_load_use();
    drain();
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    set_id(5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if ({Stall, BubbleEX, PCWrite, IFIDWrite} !== 4'b1100) begin
      errors++;
      $display("FAIL load_use_stall: got %b expected 1100",
               {Stall, BubbleEX, PCWrite, IFIDWrite});
    end
    step();
    checks++;
    if ({Stall, BubbleEX, PCWrite, IFIDWrite} !== 4'b0011) begin
      errors++;
      $display("FAIL load_use_release: got %b expected 0011",
               {Stall, BubbleEX, PCWrite, IFIDWrite});
    end
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2} !== 2'b00) begin
      errors++;
      $display("FAIL load_use_bubble_sel: got %b expected 00", {FwdA_Ctrl1, FwdA_Ctrl2});
    end
    step();
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2} !== 4'b1000) begin
      errors++;
      $display("FAIL load_use_memwb: got %b expected 1000",
               {FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2});
    end
  endtask

  task automatic test_reg_zero();
    drain();
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++;
      $display("FAIL zero_no_stall: got %b expected 0", Stall);
    end
    step();
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2} !== 4'b0000) begin
      errors++;
      $display("FAIL zero_no_fwd: got %b expected 0000",
               {FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2});
    end
  endtask

  task automatic test_unused_operand();
    drain();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    set_id(5'd3, 1'b0, 5'd3, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2} !== 4'b0000) begin
      errors++;
      $display("FAIL unused_no_fwd: got %b expected 0000",
               {FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2});
    end
  endtask

  // add $3, add $4, then Rs=4 Rt=3; then Rs=Rt=4 after another add $4
  task automatic test_independent_and_same();
    drain();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    set_id(5'd4, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2} !== 4'b0110) begin
      errors++;
      $display("FAIL independent: got %b expected 0110",
               {FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2});
    end
    // $4 now written by the previous two instructions: nearest (EX) wins
    set_id(5'd4, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2} !== 4'b0101) begin
      errors++;
      $display("FAIL same_reg_nearest: got %b expected 0101",
               {FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2});
    end
  endtask

  task automatic test_flush_hazard();
    drain();
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
    #1;
    checks++;
    if ({Stall, BubbleEX, PCWrite} !== 3'b011) begin
      errors++;
      $display("FAIL flush_wins: got %b expected 011", {Stall, BubbleEX, PCWrite});
    end
    step();
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2} !== 4'b0000) begin
      errors++;
      $display("FAIL flush_sel: got %b expected 0000",
               {FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2});
    end
    // Flushed instruction must not occupy EX: reading $6 finds no producer
    set_id(5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2} !== 4'b0010) begin
      errors++;
      $display("FAIL flush_squashed: got %b expected 0010",
               {FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2});
    end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    set_id(5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_stall: got %b expected 1", Stall);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({Stall, PCWrite, IFIDWrite, BubbleEX} !== 4'b0110) begin
      errors++;
      $display("FAIL reset_mid_stall: got %b expected 0110",
               {Stall, PCWrite, IFIDWrite, BubbleEX});
    end
    step();
    Reset = 1'b0;
    step();
    checks++;
    if ({FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_discard: got %b expected 0000",
               {FwdA_Ctrl1, FwdA_Ctrl2, FwdB_Ctrl1, FwdB_Ctrl2});
    end
  endtask

  initial begin
    test_reset();
    test_fwd_a_exmem();
    test_fwd_b_distance(0, 2'b01);
    test_fwd_b_distance(1, 2'b10);
    test_fwd_b_distance(2, 2'b11);
    test_fwd_b_distance(3, 2'b00);
    test_load_use();
    test_reg_zero();
    test_unused_operand();
    test_independent_and_same();
    test_flush_hazard();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
